// File: rtl/ysyx_23060072_if_pkg.sv
// ysyx_23060072_if_pkg
//   Definitions shared by the instruction-fetch stage and its static predictor.
//   OPC_JAL / OPC_BRANCH : RV32 opcodes the predictor decodes
//   NOP_INSTR            : addi x0,x0,0, driven on instr_o while the queue is empty
//   fetch_entry_t        : one fetch-queue entry {pc, instr, pred}
package ysyx_23060072_if_pkg;

   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
   } fetch_entry_t;

endpackage

// File: rtl/ysyx_23060072_static_bpu.sv
// ysyx_23060072_static_bpu
//   Combinational static branch predictor. It predicts JAL as taken, and it
//   predicts backward conditional branches (sign bit of imm_b set) as taken.
//   Every other instruction is predicted not taken.
//   instr  in  32  fetched instruction word
//   pc     in  32  address of that word
//   taken  out  1  predicted taken
//   target out 32  predicted target (pc + immediate); meaningful only when taken
module ysyx_23060072_static_bpu
   import ysyx_23060072_if_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output logic        taken,
   output logic [31:0] target
);

   logic [31:0] imm_j;
   logic [31:0] imm_b;

   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

   always_comb begin
      taken  = 1'b0;
      target = pc + imm_j;
      if (instr[6:0] == OPC_JAL) begin
         taken  = 1'b1;
         target = pc + imm_j;
      end else if (instr[6:0] == OPC_BRANCH && instr[31]) begin
         taken  = 1'b1;
         target = pc + imm_b;
      end
   end

endmodule

// File: rtl/ysyx_23060072_ifq_stage.sv
// ysyx_23060072_ifq_stage
//   Instruction-fetch stage with a decoupled fetch queue. It issues pipelined
//   requests to instruction memory and keeps at most MAX_OUTST of them in
//   flight. In-order responses are buffered together with their PC and
//   prediction bit, and the stage hands them to id_ex_stage over valid/ready.
//   A redirect, or a taken prediction, discards the stale responses that are
//   still in flight.
//   Optional feature: define YSYX_23060072_BPU_EN to enable static prediction.
//
//   clk, rst_n                : clock, asynchronous active-low reset
//   redirect_i/redirect_pc_i  : controller flush/jump pulse and its target
//   req_valid_o/req_ready_i   : fetch request handshake, address on req_addr_o
//   resp_valid_i/resp_rdata_i : in-order instruction responses (no back-pressure)
//   valid_o/ready_i           : queue-head handshake toward id_ex_stage
//   pc_o/instr_o/predict_flag_o : queue-head contents (0 / NOP / 0 when empty)
module ysyx_23060072_ifq_stage
   import ysyx_23060072_if_pkg::*;
#(
   parameter int unsigned QDEPTH    = 4,
   parameter int unsigned MAX_OUTST = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        req_valid_o,
   input  logic        req_ready_i,
   output logic [31:0] req_addr_o,
   input  logic        resp_valid_i,
   input  logic [31:0] resp_rdata_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        predict_flag_o
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUTST + 1);
   localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   logic [31:0]  fetch_pc;
   logic [OW-1:0] outst;
   logic [OW-1:0] outst_next;
   logic [OW-1:0] drop_cnt;

   fetch_entry_t q_mem [QDEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   fetch_entry_t  head;

   // The tag FIFO holds the PC of every outstanding request, so it always
   // contains exactly outst entries. Stale requests keep their tags until
   // their responses arrive.
   logic [31:0]   tag_mem [MAX_OUTST];
   logic [TW-1:0] tag_rd;
   logic [TW-1:0] tag_wr;
   logic [31:0]   resp_pc;

   logic req_fire;
   logic pop;
   logic push;
   logic taken;
   logic bpu_taken;
   logic [31:0] bpu_target;

`ifdef YSYX_23060072_BPU_EN
   ysyx_23060072_static_bpu u_bpu (
      .instr  (resp_rdata_i),
      .pc     (resp_pc),
      .taken  (bpu_taken),
      .target (bpu_target)
   );
`else
   assign bpu_taken  = 1'b0;
   assign bpu_target = '0;
`endif

   // Credit rule: each in-flight request reserves a queue slot, so a push
   // never finds the queue full.
   assign req_valid_o = rst_n && !redirect_i
                        && (32'(outst) < MAX_OUTST)
                        && (32'(outst) + 32'(count) < QDEPTH);
   assign req_addr_o  = fetch_pc;
   assign req_fire    = req_valid_o && req_ready_i;

   assign resp_pc = tag_mem[tag_rd];
   assign push    = resp_valid_i && !redirect_i && (drop_cnt == '0);
   assign taken   = push && bpu_taken;
   assign pop     = valid_o && ready_i;

   assign outst_next = outst + OW'(req_fire) - OW'(resp_valid_i);

   assign head           = q_mem[rd_ptr];
   assign valid_o        = (count != '0);
   assign pc_o           = valid_o ? head.pc : '0;
   assign instr_o        = valid_o ? head.instr : NOP_INSTR;
   assign predict_flag_o = valid_o && head.pred;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         outst    <= '0;
         drop_cnt <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         tag_rd   <= '0;
         tag_wr   <= '0;
      end else begin
         outst <= outst_next;

         if (req_fire)
            tag_wr <= (tag_wr == TW'(MAX_OUTST - 1)) ? '0 : tag_wr + TW'(1);
         if (resp_valid_i)
            tag_rd <= (tag_rd == TW'(MAX_OUTST - 1)) ? '0 : tag_rd + TW'(1);

         // No request is issued in a redirect cycle, so outst_next is also
         // the number of requests that are still in flight after the redirect.
         if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            drop_cnt <= outst_next;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (taken) begin
               fetch_pc <= {bpu_target[31:2], 2'b00};
               drop_cnt <= outst_next;
            end else begin
               if (req_fire)
                  fetch_pc <= fetch_pc + 32'd4;
               if (resp_valid_i && drop_cnt != '0)
                  drop_cnt <= drop_cnt - OW'(1);
            end
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         q_mem[wr_ptr] <= '{pc: resp_pc, instr: resp_rdata_i, pred: bpu_taken};
      if (req_fire)
         tag_mem[tag_wr] <= fetch_pc;
   end

endmodule
